// File: rtl/resp_compactor.sv
// Response compactor: folds one response word per accepted beat into a MISR,
// then compares the final signature against a golden value.
module resp_compactor #(
   parameter int RESP_W = 2,
   parameter int SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY = 16'h1021,
   parameter logic [SIG_W-1:0] SEED = '0,
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_patterns,
   input  logic [SIG_W-1:0] golden,
   input  logic             resp_valid,
   input  logic [RESP_W-1:0] resp,
   output logic             resp_ready,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature,
   output logic [CNT_W-1:0] pattern_count
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_CHECK = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]       state;
   logic [CNT_W-1:0] target;
   logic             beat;

   // One MISR step: shift left, apply feedback when the MSB falls out, fold in the word.
   function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                  input logic [RESP_W-1:0] word);
      logic [SIG_W-1:0] nxt;
      nxt = {sig[SIG_W-2:0], 1'b0};
      if (sig[SIG_W-1])
         nxt = nxt ^ POLY;
      return nxt ^ SIG_W'(word);
   endfunction

   assign resp_ready = (state == ST_RUN);
   assign busy       = (state == ST_RUN) || (state == ST_CHECK);
   assign done       = (state == ST_DONE);
   assign beat       = resp_valid && resp_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         signature     <= SEED;
         pattern_count <= '0;
         pass          <= 1'b0;
         target        <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  signature     <= SEED;
                  pattern_count <= '0;
                  pass          <= 1'b0;
                  target        <= num_patterns;
                  state         <= (num_patterns == '0) ? ST_CHECK : ST_RUN;
               end
            end
            ST_RUN: begin
               if (beat) begin
                  signature     <= misr_step(signature, resp);
                  pattern_count <= pattern_count + CNT_W'(1);
                  if (pattern_count == target - CNT_W'(1))
                     state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               pass  <= (signature == golden);
               state <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_resp_compactor.sv
// Scoreboard bench for resp_compactor: stimulus pushes expected results, a
// monitor pops and compares on every accepted beat and on each rise of done.
module tb_resp_compactor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [9:0]  num_patterns;
   logic [15:0] golden;
   logic        resp_valid;
   logic [1:0]  resp;
   logic        resp_ready, busy, done, pass;
   logic [15:0] signature;
   logic [9:0]  pattern_count;

   int total = 0;
   int bad = 0;

   typedef struct {
      bit          is_end;
      logic [15:0] sig;
      logic [9:0]  cnt;
      bit          pass;
   } exp_t;
   exp_t q[$];

   resp_compactor dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_patterns(num_patterns),
      .golden(golden), .resp_valid(resp_valid), .resp(resp),
      .resp_ready(resp_ready), .busy(busy), .done(done), .pass(pass),
      .signature(signature), .pattern_count(pattern_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor
   bit beat_seen = 0;
   bit prev_done = 0;
   always @(posedge clk) beat_seen <= resp_valid && resp_ready && rst_n;

   always @(negedge clk) begin
      exp_t e;
      if (beat_seen) begin
         if (q.size() == 0) chk("beat_unexpected", 1, 0);
         else begin
            e = q.pop_front();
            chk("beat_kind", {31'd0, e.is_end}, 0);
            chk("beat_sig", {16'd0, signature}, {16'd0, e.sig});
            chk("beat_cnt", {22'd0, pattern_count}, {22'd0, e.cnt});
         end
      end
      if (done && !prev_done) begin
         if (q.size() == 0) chk("done_unexpected", 1, 0);
         else begin
            e = q.pop_front();
            chk("end_kind", {31'd0, e.is_end}, 1);
            chk("end_sig", {16'd0, signature}, {16'd0, e.sig});
            chk("end_pass", {31'd0, pass}, {31'd0, e.pass});
         end
      end
      prev_done = done;
   end

   task automatic push_end(input logic [15:0] s, input bit p);
      exp_t e;
      e.is_end = 1; e.sig = s; e.cnt = '0; e.pass = p;
      q.push_back(e);
   endtask

   task automatic send(input logic [1:0] r, input logic [15:0] s, input logic [9:0] c);
      exp_t e;
      int w = 0;
      while (!resp_ready && w < 20) begin @(negedge clk); w++; end
      if (!resp_ready) chk("ready_timeout", 0, 1);
      else begin
         e.is_end = 0; e.sig = s; e.cnt = c; e.pass = 0;
         q.push_back(e);
         resp_valid = 1'b1;
         resp = r;
         @(negedge clk);
         resp_valid = 1'b0;
         resp = 2'($urandom);
      end
   endtask

   task automatic do_start(input logic [9:0] n);
      start = 1'b1;
      num_patterns = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int w = 0;
      while (!done && w < 20) begin @(negedge clk); w++; end
      if (!done) chk("done_timeout", 0, 1);
   endtask

   task automatic basic_run();
      golden = 16'h0003;
      do_start(10'd3);
      send(2'b01, 16'h0001, 10'd1);
      send(2'b10, 16'h0000, 10'd2);
      send(2'b11, 16'h0003, 10'd3);
      push_end(16'h0003, 1);
      chk("basic_not_yet_done", {31'd0, done}, 0);
      chk("basic_busy_check", {31'd0, busy}, 1);
      @(negedge clk);
      chk("basic_done", {31'd0, done}, 1);
      chk("basic_pass", {31'd0, pass}, 1);
   endtask

   initial begin
      logic [15:0] e;
      rst_n = 1'b0; start = 1'b0; num_patterns = '0; golden = '0;
      resp_valid = 1'b0; resp = '0;
      repeat (3) @(negedge clk);
      chk("rst_sig", {16'd0, signature}, 0);
      chk("rst_cnt", {22'd0, pattern_count}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_pass", {31'd0, pass}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_ready", {31'd0, resp_ready}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic pass
      basic_run();

      // Feedback tap: walk a single 1 up to the MSB, then one more shift taps POLY
      for (int pol = 0; pol < 2; pol++) begin
         golden = (pol == 0) ? 16'h1021 : 16'h1020;
         do_start(10'd17);
         send(2'b01, 16'h0001, 10'd1);
         for (int k = 1; k <= 15; k++) begin
            e = 16'h0001 << k;
            send(2'b00, e, 10'(k + 1));
         end
         chk("fb_msb", {16'd0, signature}, 32'h8000);
         send(2'b00, 16'h1021, 10'd17);
         push_end(16'h1021, (pol == 0));
         wait_done();
      end

      // Backpressure gaps
      golden = 16'h0003;
      do_start(10'd3);
      send(2'b01, 16'h0001, 10'd1);
      repeat (2) begin
         resp = 2'b11;
         @(negedge clk);
         chk("gap1_cnt", {22'd0, pattern_count}, 1);
      end
      send(2'b10, 16'h0000, 10'd2);
      repeat (2) begin
         @(negedge clk);
         chk("gap2_cnt", {22'd0, pattern_count}, 2);
         chk("gap2_sig", {16'd0, signature}, 0);
      end
      send(2'b11, 16'h0003, 10'd3);
      push_end(16'h0003, 1);
      wait_done();

      // Zero patterns
      golden = 16'h0000;
      push_end(16'h0000, 1);
      do_start(10'd0);
      chk("zero_check_state", {31'd0, done}, 0);
      chk("zero_ready_a", {31'd0, resp_ready}, 0);
      @(negedge clk);
      chk("zero_done", {31'd0, done}, 1);
      chk("zero_pass", {31'd0, pass}, 1);
      chk("zero_ready_b", {31'd0, resp_ready}, 0);

      // Reset mid-run
      golden = 16'h0003;
      do_start(10'd3);
      send(2'b01, 16'h0001, 10'd1);
      rst_n = 1'b0;
      resp_valid = 1'b1; resp = 2'b10;
      @(negedge clk);
      resp_valid = 1'b0;
      rst_n = 1'b1;
      chk("mid_rst_sig", {16'd0, signature}, 0);
      chk("mid_rst_cnt", {22'd0, pattern_count}, 0);
      chk("mid_rst_busy", {31'd0, busy}, 0);
      chk("mid_rst_ready", {31'd0, resp_ready}, 0);
      chk("mid_rst_done", {31'd0, done}, 0);
      chk("mid_rst_pass", {31'd0, pass}, 0);
      basic_run();

      // Ignored start during RUN, then a start from DONE
      do_start(10'd3);
      send(2'b01, 16'h0001, 10'd1);
      start = 1'b1; num_patterns = 10'd5;
      @(negedge clk);
      start = 1'b0;
      chk("ign_cnt", {22'd0, pattern_count}, 1);
      chk("ign_sig", {16'd0, signature}, 1);
      chk("ign_busy", {31'd0, busy}, 1);
      send(2'b10, 16'h0000, 10'd2);
      send(2'b11, 16'h0003, 10'd3);
      push_end(16'h0003, 1);
      wait_done();
      chk("ign_done", {31'd0, done}, 1);
      do_start(10'd3);
      chk("restart_done", {31'd0, done}, 0);
      chk("restart_pass", {31'd0, pass}, 0);
      chk("restart_ready", {31'd0, resp_ready}, 1);
      chk("restart_cnt", {22'd0, pattern_count}, 0);
      send(2'b01, 16'h0001, 10'd1);
      send(2'b10, 16'h0000, 10'd2);
      send(2'b11, 16'h0003, 10'd3);
      push_end(16'h0003, 1);
      wait_done();
      @(negedge clk);

      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
